// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared EX-stage definitions: ALU type codes, M-extension funct3 codes and
// the multiply/divide FSM state encoding.
package ex_muldiv_ctrl_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_type_t;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_t;

   localparam logic [5:0] LAST_ITER = 6'd31;

   function automatic logic rs1_is_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/ex_divider_core.sv
// Restoring-division datapath: load latches magnitudes, each step retires one
// quotient bit. Step results are exposed combinationally so the caller can
// capture the final bit in the same edge.
module ex_divider_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quo_step,
   output logic [XLEN-1:0] rem_step
);

   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] div_q;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            fits;

   always_comb begin
      shifted  = {rem_q, quo_q[XLEN-1]};
      fits     = (shifted >= {1'b0, div_q});
      // When the trial fits, the true difference is below the divisor, so the
      // low XLEN bits of the wrapped subtraction are exact.
      diff     = shifted[XLEN-1:0] - div_q;
      rem_step = fits ? diff : shifted[XLEN-1:0];
      quo_step = {quo_q[XLEN-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (load) begin
         quo_q <= dividend;
         rem_q <= '0;
         div_q <= divisor;
      end else if (step) begin
         quo_q <= quo_step;
         rem_q <= rem_step;
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage M-extension controller: iterative multiply/divide FSM with stall.
// Define EX_MULDIV_FAST_MUL_EN for single-cycle combinational multiply.
module ex_muldiv_ctrl
   import ex_muldiv_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_addr_in,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_addr_out,
   output logic            rd_wen
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

   function automatic logic [XLEN-1:0] fix_sign_w(input logic [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] fix_sign_d(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   md_state_t         state, state_nxt;
   logic [5:0]        cnt;
   logic [2:0]        op_q;
   logic [4:0]        rd_q;
   logic              neg_q;
   logic              rem_neg_q;
   logic [2*XLEN-1:0] mul_a;
   logic [2*XLEN-1:0] mul_acc;
   logic [XLEN-1:0]   mul_b;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_out_q;

   logic              s1, s2;
   logic [XLEN-1:0]   mag1, mag2;
   logic              div_op, div_zero, div_ovf, fast_mul, bypass;
   logic              accept, last_iter, capture_iter;
   logic [XLEN-1:0]   special_res, fast_res, iter_res;
   logic [2*XLEN-1:0] mul_acc_nxt, prod_fix;
   logic [XLEN-1:0]   quo_step, rem_step;

   always_comb begin
      s1          = rs1_is_signed(op);
      s2          = rs2_is_signed(op);
      mag1        = magnitude(rs1_data, s1);
      mag2        = magnitude(rs2_data, s2);
      div_op      = op[2];
      div_zero    = div_op && (rs2_data == '0);
      div_ovf     = div_op && !op[0] && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONE);
      // op[1] selects the remainder flavour of DIV/DIVU vs REM/REMU.
      special_res = op[1] ? (div_zero ? rs1_data : '0) : (div_zero ? ALL_ONE : MIN_NEG);
   end

`ifdef EX_MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fast_prod;
   always_comb begin
      fast_mul  = !op[2];
      fast_prod = $signed({{XLEN{s1 & rs1_data[XLEN-1]}}, rs1_data}) *
                  $signed({{XLEN{s2 & rs2_data[XLEN-1]}}, rs2_data});
      fast_res  = (op == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
   end
`else
   always_comb begin
      fast_mul = 1'b0;
      fast_res = '0;
   end
`endif

   assign bypass = div_zero || div_ovf || fast_mul;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_iter = (cnt == LAST_ITER);
      case (state)
         ST_IDLE: begin
            if (start && !flush) begin
               accept = 1'b1;
               if (bypass)      state_nxt = ST_DONE;
               else if (div_op) state_nxt = ST_DIV;
               else             state_nxt = ST_MUL;
            end
         end
         ST_MUL, ST_DIV: begin
            if (flush)          state_nxt = ST_IDLE;
            else if (last_iter) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      capture_iter = ((state == ST_MUL) || (state == ST_DIV)) && last_iter && !flush;
   end

   ex_divider_core #(
      .XLEN (XLEN)
   ) u_div (
      .clk      (clk),
      .load     (accept),
      .step     (state == ST_DIV),
      .dividend (mag1),
      .divisor  (mag2),
      .quo_step (quo_step),
      .rem_step (rem_step)
   );

   always_comb begin
      mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
      prod_fix    = fix_sign_d(mul_acc_nxt, neg_q);
      if (state == ST_MUL)
         iter_res = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      else if (op_q[1])
         iter_res = fix_sign_w(rem_step, rem_neg_q);
      else
         iter_res = fix_sign_w(quo_step, neg_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= '0;
         else if (((state == ST_MUL) || (state == ST_DIV)) && !flush && !last_iter)
            cnt <= cnt + 6'd1;
         if (accept && bypass) begin
            result_q <= fast_mul ? fast_res : special_res;
            rd_out_q <= rd_addr_in;
         end else if (capture_iter) begin
            result_q <= iter_res;
            rd_out_q <= rd_q;
         end
      end
   end

   // Operand datapath: loaded on accept, shifted while multiplying.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q      <= op;
         rd_q      <= rd_addr_in;
         neg_q     <= (s1 & rs1_data[XLEN-1]) ^ (s2 & rs2_data[XLEN-1]);
         rem_neg_q <= s1 & rs1_data[XLEN-1];
         mul_a     <= {{XLEN{1'b0}}, mag1};
         mul_b     <= mag2;
         mul_acc   <= '0;
      end else if (state == ST_MUL) begin
         mul_a   <= mul_a << 1;
         mul_b   <= mul_b >> 1;
         mul_acc <= mul_acc_nxt;
      end
   end

   assign busy        = (state == ST_MUL) || (state == ST_DIV);
   assign done        = (state == ST_DONE);
   assign stall       = rst_n && ((start && (state == ST_IDLE)) || busy);
   assign result      = result_q;
   assign rd_addr_out = rd_out_q;
   assign rd_wen      = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: cycle-exact done/stall timing, special
// cases, flush and mid-operation reset.
module tb_ex_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_addr_in;
   logic        flush;
   logic        stall, busy, done, rd_wen;
   logic [31:0] result;
   logic [4:0]  rd_addr_out;

   int checks = 0;
   int errors = 0;

`ifdef EX_MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   always #5 clk = ~clk;

   ex_muldiv_ctrl #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rd_addr_in  (rd_addr_in),
      .flush       (flush),
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .rd_addr_out (rd_addr_out),
      .rd_wen      (rd_wen)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Start an op in the current cycle C and check every cycle up to C+lat+1.
   task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat, input logic hold);
      start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr_in = rd;
      #3;
      chk({tag, " stall_C"}, stall, 1);
      chk({tag, " done_C"}, done, 0);
      for (int k = 1; k < lat; k++) begin
         nxt();
         start = hold;
         #3;
         chk({tag, " done_early"}, done, 0);
         chk({tag, " stall_run"}, stall, 1);
      end
      nxt();
      start = 1'b0;
      #3;
      chk({tag, " done"}, done, 1);
      chk({tag, " stall_done"}, stall, 0);
      chk({tag, " busy_done"}, busy, 0);
      chk({tag, " result"}, result, exp);
      chk({tag, " rd_addr_out"}, {27'd0, rd_addr_out}, {27'd0, rd});
      chk({tag, " rd_wen"}, rd_wen, (rd != 5'd0));
      nxt();
      #3;
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " result_hold"}, result, exp);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
      rd_addr_in = '0; flush = 1'b0;
      nxt();
      nxt();
      start = 1'b1;
      #3;
      chk("rst stall", stall, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst result", result, 0);
      chk("rst rd_addr_out", {27'd0, rd_addr_out}, 0);
      chk("rst rd_wen", rd_wen, 0);
      start = 1'b0;
      nxt();
      rst_n = 1'b1;
      nxt();

      issue("div_100_7",    3'd4, 32'd100,      32'd7,        5'd3, 32'd14,       33, 1'b0);
      issue("rem_m100_7",   3'd6, 32'hFFFFFF9C, 32'd7,        5'd4, 32'hFFFFFFFE, 33, 1'b0);
      issue("div_m100_7",   3'd4, 32'hFFFFFF9C, 32'd7,        5'd7, 32'hFFFFFFF2, 33, 1'b0);
      issue("remu_100_7",   3'd7, 32'd100,      32'd7,        5'd8, 32'd2,        33, 1'b0);
      issue("divu_by0",     3'd5, 32'd5,        32'd0,        5'd0, 32'hFFFFFFFF,  1, 1'b0);
      issue("rem_by0",      3'd6, 32'hFFFFFF9C, 32'd0,        5'd2, 32'hFFFFFF9C,  1, 1'b0);
      issue("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000,  1, 1'b0);
      issue("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'd0,         1, 1'b0);
      issue("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000, MUL_LAT, 1'b1);
      issue("mul_m3_7",     3'd0, 32'hFFFFFFFD, 32'd7,        5'd11, 32'hFFFFFFEB, MUL_LAT, 1'b0);
      issue("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, MUL_LAT, 1'b0);
      issue("mulhsu_m1_2",  3'd2, 32'hFFFFFFFF, 32'd2,        5'd13, 32'hFFFFFFFF, MUL_LAT, 1'b0);

      // Flush an in-flight DIVU at C+10, restart at C+11.
      start = 1'b1; op = 3'd5; rs1_data = 32'd1000; rs2_data = 32'd3; rd_addr_in = 5'd9;
      #3;
      chk("flush stall_C", stall, 1);
      for (int k = 1; k <= 10; k++) begin
         nxt();
         start = 1'b0;
         if (k == 10) flush = 1'b1;
         #3;
         chk("flush busy_run", busy, 1);
         chk("flush done_run", done, 0);
      end
      nxt();
      flush = 1'b0;
      #3;
      chk("flush busy_after", busy, 0);
      chk("flush done_after", done, 0);
      chk("flush stall_after", stall, 0);
      chk("flush result_kept", result, 32'hFFFFFFFF);
      issue("divu_after_flush", 3'd5, 32'd1000, 32'd3, 5'd9, 32'd333, 33, 1'b0);

      // Reset asserted during an iterative MUL.
      start = 1'b1; op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4; rd_addr_in = 5'd5;
      for (int k = 1; k <= 5; k++) begin
         nxt();
         start = 1'b0;
         if (k == 5) rst_n = 1'b0;
         #3;
         chk("mrst busy_run", busy, (MUL_LAT == 33) ? 1 : 0);
      end
      nxt();
      start = 1'b1;
      #3;
      chk("mrst stall", stall, 0);
      chk("mrst busy", busy, 0);
      chk("mrst done", done, 0);
      chk("mrst result", result, 0);
      chk("mrst rd_addr_out", {27'd0, rd_addr_out}, 0);
      chk("mrst rd_wen", rd_wen, 0);
      start = 1'b0;
      nxt();
      rst_n = 1'b1;
      #3;
      chk("mrst busy_hold", busy, 0);
      nxt();
      issue("divu_after_rst", 3'd5, 32'd7, 32'd2, 5'd1, 32'd3, 33, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  EX requests an M-extension op this cycle.
REQ-005 op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1_data, rs2_data  input  32 each  operands from the ID/EX register.
REQ-007 rd_addr_in  input  5  destination register.
REQ-008 flush  input  1  abort any in-flight op.
REQ-009 stall  output  1  freeze PC, IF/ID and ID/EX.
REQ-010 busy  output  1  state is neither IDLE nor DONE.
REQ-011 done  output  1  result valid, single-cycle pulse.
REQ-012 result  output  32  op result, valid while done=1.
REQ-013 rd_addr_out  output  5; rd_wen  output  1  regfile write port, rd_wen = done and rd_addr_out != 0.

Function
REQ-014 The FSM states SHALL be IDLE, MUL, DIV and DONE.
- IDLE + start → MUL (op 0-3) or DIV (op 4-7), latching operands, op and rd_addr.
- MUL/DIV → DONE after 32 iterations.
- DONE → IDLE unconditionally.
REQ-015 For a start sampled in cycle C in IDLE, done SHALL be high in cycle C+33 for iterative ops and in cycle C+1 for special cases.
REQ-016 stall SHALL equal (start and state==IDLE) or busy, so it is high in cycles C..C+32 and low in the done cycle.
REQ-017 start SHALL be ignored in MUL, DIV and DONE; a new start is accepted only in IDLE.
REQ-018 Multiply SHALL use 32-cycle shift-add on 64-bit magnitudes with a sign fix-up.
- MUL returns product[31:0].
- MULH, MULHSU and MULHU return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-019 Divide SHALL use 32-cycle restoring division on magnitudes; the quotient sign is the XOR of the operand signs and the remainder sign is the dividend sign (signed ops only).
REQ-020 Division by zero SHALL bypass iteration (IDLE→DONE) and return quotient 0xFFFFFFFF and remainder rs1.
REQ-021 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM) SHALL bypass iteration and return quotient 0x80000000 and remainder 0.
REQ-022 A 6-bit iteration counter SHALL load 0 on accept, increment once per MUL/DIV cycle and exit at 31; it SHALL never wrap.
REQ-023 flush SHALL force IDLE at the next edge from any state with no done pulse.
- flush has priority over start in the same cycle.
- flush in the DONE cycle does not suppress that cycle's done.
REQ-024 result, rd_addr_out and rd_wen SHALL hold their previous value outside done; consumers qualify them with done.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE and zero the counter and result, and clear done, busy, rd_wen and rd_addr_out; reset mid-operation discards the op.
REQ-026 stall SHALL be low during reset regardless of start.

Configuration
REQ-027 With EX_MULDIV_FAST_MUL_EN defined, multiply ops SHALL compute combinationally and go IDLE→DONE, with done in cycle C+1; without it, multiply follows REQ-018.
REQ-028 Divide timing SHALL be identical under both settings.

Structure
REQ-029 M-extension funct3 constants and the FSM state encoding SHALL live in the shared define header, beside the existing ALU type codes.
REQ-030 One sub-module, ex_divider_core (the iteration datapath with a load/step interface), SHALL be instantiated; the FSM, special-case detection and sign fix-up stay in ex_muldiv_ctrl.

Verification
REQ-031 The bench SHALL cover the following directed scenarios:
- DIV rs1=100, rs2=7, start at C → done at C+33 with result 14; stall high C..C+32.
- REM rs1=0xFFFFFF9C (-100), rs2=7 → result 0xFFFFFFFE (-2); DIVU rs1=5, rs2=0 → result 0xFFFFFFFF at C+1.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → result 0x80000000 at C+1; REM of the same operands → result 0.
- MULH rs1=0x80000000, rs2=0x80000000 → result 0x40000000 at C+33 (C+1 with EX_MULDIV_FAST_MUL_EN).
- DIVU started, flush at C+10 → no done, IDLE at C+11; a new start at C+11 completes normally.
- MUL running, rst_n=0 at C+5 → all outputs at reset values at C+6; start held high during busy is ignored; rd_addr_in=0 → done with rd_wen=0.
